// File: rtl/dram_bist_top.sv
// Switch-driven DEPTH x WIDTH distributed RAM with a W0/R0/R1 march BIST.
// Switches are double-flop synchronised; status and read data go to the LEDs.
module dram_bist_top #(
  parameter int ADDR_W     = 7,
  parameter int WIDTH      = 2,
  parameter int INIT_WORD  = 0,
  parameter int FAULT_ADDR = -1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic        tx,
  input  logic [15:0] sw,
  output logic [15:0] led
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;

  function automatic logic [WIDTH-1:0] pat_f();
    logic [WIDTH-1:0] p;
    for (int i = 0; i < WIDTH; i++) p[i] = ((i % 2) == 0);
    return p;
  endfunction

  localparam logic [WIDTH-1:0]  PAT      = pat_f();
  localparam logic [WIDTH-1:0]  NPAT     = ~PAT;
  localparam bit                FAULT_EN = (FAULT_ADDR >= 0) && (FAULT_ADDR < DEPTH);
  localparam logic [ADDR_W-1:0] FAULT_A  = ADDR_W'(FAULT_EN ? FAULT_ADDR : 0);

  typedef enum logic [2:0] {S_IDLE, S_W0, S_R0, S_R1, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              fail_q, fail_d;
  logic [15:0]       sync1_q, ssw_q;
  logic              start_prev_q;

  // No reset on the array: contents must survive rst_n.
  logic [WIDTH-1:0]  mem [DEPTH] = '{default: WIDTH'(INIT_WORD)};

  logic              mem_we;
  logic [ADDR_W-1:0] mem_wa;
  logic [WIDTH-1:0]  mem_wd, mem_rd, man_rd;
  logic [ADDR_W-1:0] sw_addr;
  logic [WIDTH-1:0]  sw_data;
  logic              start, busy, fault_hit;
  logic              sw_unused;

  assign tx        = rx;
  assign sw_addr   = ssw_q[ADDR_W-1:0];
  assign sw_data   = ssw_q[7 +: WIDTH];
  assign sw_unused = ^ssw_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      ssw_q        <= '0;
      start_prev_q <= 1'b0;
      state_q      <= S_IDLE;
      addr_q       <= '0;
      fail_q       <= 1'b0;
    end else begin
      sync1_q      <= sw;
      ssw_q        <= sync1_q;
      start_prev_q <= ssw_q[14];
      state_q      <= state_d;
      addr_q       <= addr_d;
      fail_q       <= fail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  assign mem_rd = mem[addr_q];
  assign man_rd = mem[sw_addr];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    fail_d    = fail_q;
    mem_we    = 1'b0;
    mem_wa    = sw_addr;
    mem_wd    = sw_data;
    busy      = 1'b0;
    start     = ssw_q[14] & ~start_prev_q;
    fault_hit = FAULT_EN && (addr_q == FAULT_A);
    case (state_q)
      S_W0: begin
        busy   = 1'b1;
        mem_we = 1'b1;
        mem_wa = addr_q;
        mem_wd = PAT ^ WIDTH'(fault_hit);
        if (addr_q == LAST) begin
          state_d = S_R0;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_R0: begin
        // Read-compare and write-back of the inverse happen in the same cycle.
        busy   = 1'b1;
        mem_we = 1'b1;
        mem_wa = addr_q;
        mem_wd = NPAT ^ WIDTH'(fault_hit);
        if (mem_rd != PAT) fail_d = 1'b1;
        if (addr_q == LAST) begin
          state_d = S_R1;
          addr_d  = LAST;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_R1: begin
        busy = 1'b1;
        if (mem_rd != NPAT) fail_d = 1'b1;
        if (addr_q == '0) state_d = S_DONE;
        else              addr_d  = addr_q - 1'b1;
      end
      default: begin
        // IDLE and DONE: manual access; a start edge may coincide with a write.
        mem_we = ssw_q[15];
        if (start) begin
          state_d = S_W0;
          addr_d  = '0;
          fail_d  = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    led            = '0;
    led[WIDTH-1:0] = busy ? '0 : man_rd;
    led[12]        = busy;
    led[13]        = (state_q == S_DONE);
    led[14]        = (state_q == S_DONE) & ~fail_q;
    led[15]        = fail_q;
  end
endmodule

// File: tb/tb_dram_bist_top.sv
// Directed bench: default, fault-injected (addr 5) and 16x4 instances share stimulus.
module tb_dram_bist_top;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b0;
  logic [15:0] sw = '0;
  logic [15:0] led0, led1, led2;
  logic        tx0, tx1, tx2;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  dram_bist_top u_dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx0), .sw(sw), .led(led0)
  );
  dram_bist_top #(.FAULT_ADDR(5)) u_flt (
    .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx1), .sw(sw), .led(led1)
  );
  dram_bist_top #(.ADDR_W(4), .WIDTH(4)) u_small (
    .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx2), .sw(sw), .led(led2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Start a BIST on all three instances and count busy cycles over a fixed window.
  task automatic bist_run(input string tag, input bit hold14, input bit wr_during);
    int c0, c1, c2;
    c0 = 0; c1 = 0; c2 = 0;
    @(negedge clk);
    sw = 16'h4000;
    if (wr_during) sw = sw | 16'h8000 | (16'h3 << 7) | 16'd2;
    for (int i = 0; i < 460; i++) begin
      @(negedge clk);
      if (led0[12]) c0++;
      if (led1[12]) c1++;
      if (led2[12]) c2++;
      if (i % 64 == 0) chk({tag, "_tx"}, {29'd0, tx0, tx1, tx2}, {29'd0, rx, rx, rx});
      rx = ~rx;
      if (i == 1 && !hold14) sw[14] = 1'b0;
      if (i == 20) sw[15] = 1'b0;
    end
    chk({tag, "_busy0"}, c0, 384);
    chk({tag, "_busy1"}, c1, 384);
    chk({tag, "_busy2"}, c2, 48);
    chk({tag, "_flags0"}, led0[15:12], 4'b0110);
    chk({tag, "_flags1"}, led1[15:12], 4'b1010);
    chk({tag, "_flags2"}, led2[15:12], 4'b0110);
    @(negedge clk);
    sw = '0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_led0", led0, 16'h0000);
    chk("rst_led1", led1, 16'h0000);
    chk("rst_led2", led2, 16'h0000);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rel_led0", led0, 16'h0000);

    // Manual write of 2'b11 (4'b0011 on the wide instance) to address 3.
    sw = 16'h8000 | (16'h3 << 7) | 16'd3;
    @(negedge clk);
    sw[15] = 1'b0;
    repeat (3) @(negedge clk);
    chk("man_rd3_0", led0, 16'h0003);
    chk("man_rd3_1", led1, 16'h0003);
    chk("man_rd3_2", led2, 16'h0003);
    sw = 16'd4;
    repeat (3) @(negedge clk);
    chk("man_rd4_0", led0, 16'h0000);
    chk("man_rd4_2", led2, 16'h0000);
    sw = '0;

    // Start held high across completion, manual writes attempted during BIST.
    bist_run("runA", 1'b1, 1'b1);

    for (int a = 0; a < 128; a++) begin
      @(negedge clk);
      sw = 16'(a);
      repeat (3) @(negedge clk);
      chk("rd_all0", led0[1:0], 2'b10);
      if (a < 16) chk("rd_all2", led2[3:0], 4'b1010);
    end
    sw = '0;
    repeat (3) @(negedge clk);

    // Reset in the middle of W0 on the default instance.
    sw = 16'h4000;
    repeat (2) @(negedge clk);
    sw = '0;
    repeat (100) @(negedge clk);
    chk("mid_busy0", led0[12], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst0", led0[15:12], 4'b0000);
    chk("mid_rst1", led1[15:12], 4'b0000);
    chk("mid_rst2", led2[15:12], 4'b0000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst0", led0, 16'h0001);
    chk("post_rst1", led1, 16'h0001);
    chk("post_rst2", led2, 16'h000a);

    bist_run("runB", 1'b0, 1'b0);
    chk("runB_rd0", led0, 16'h6002);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/dram_bist_top.md
DRAM_BIST_TOP -- requirements
Module: dram_bist_top

Interface
REQ-001 Parameter ADDR_W, default 7: address width, legal 1..7; DEPTH = 2**ADDR_W words.
REQ-002 Parameter WIDTH, default 2: data word width, legal 1..4.
REQ-003 Parameter INIT_WORD, default 0: initial value of every RAM word at configuration.
REQ-004 Parameter FAULT_ADDR, default -1: test hook; when in 0..DEPTH-1, BIST writes to that address store bit0 inverted; -1 = disabled.
REQ-005 clk  input  1  single clock for all sequential logic.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 rx  input  1  UART receive; not interpreted.
REQ-008 tx  output  1  driven combinationally equal to rx.
REQ-009 sw  input  16  sw[ADDR_W-1:0] address; sw[7+WIDTH-1:7] write data; sw[14] BIST start; sw[15] manual write enable.
REQ-010 led  output  16  [WIDTH-1:0] read data; [11:WIDTH] zero; [12] busy; [13] done; [14] pass; [15] fail.

Function
REQ-011 Storage SHALL be a DEPTH x WIDTH array with synchronous write on rising clk and asynchronous read, inferable as distributed RAM.
REQ-012 All sw bits SHALL pass through a 2-flop synchroniser; downstream logic uses only synchronised values (ssw).
REQ-013 Manual read: led[WIDTH-1:0] = mem[ssw address] while FSM in IDLE or DONE; 0 while busy.
REQ-014 Manual write: ssw[15]=1 in IDLE or DONE writes ssw data to ssw address every clock; ignored while busy.
REQ-015 Start: rising edge of ssw[14] (1 now, 0 previous cycle) in IDLE or DONE; ignored while busy.
REQ-016 Pattern P: bit i = 1 when i even, else 0 (WIDTH=2 -> 2'b01; WIDTH=4 -> 4'b0101).
REQ-017 FSM states IDLE, W0, R0, R1, DONE; start -> W0, pass/fail cleared, addr counter = 0.
REQ-018 W0: one cycle per address, ascending 0..DEPTH-1, write P; after DEPTH-1 -> R0, addr = 0.
REQ-019 R0: one cycle per address, ascending; compare mem to P, same cycle write ~P; after DEPTH-1 -> R1, addr = DEPTH-1.
REQ-020 R1: one cycle per address, descending; compare mem to ~P; after address 0 -> DONE.
REQ-021 Any mismatch in R0/R1 SHALL set fail (sticky until next start or reset); test continues to completion.
REQ-022 DONE: done=1; pass = ~fail; FSM remains until next start edge.
REQ-023 busy=1 exactly in W0, R0, R1; BIST duration = 3*DEPTH cycles from W0 entry to DONE entry.
REQ-024 Address counter SHALL be ADDR_W bits; no wrap beyond terminal values (transition instead).
REQ-025 FAULT_ADDR applies only to BIST writes, never manual writes.
REQ-026 Simultaneous manual write and start edge in IDLE/DONE: write occurs that cycle; BIST starts next cycle in W0.

Reset
REQ-027 rst_n low SHALL immediately force FSM IDLE, addr 0, fail 0, pass 0, done 0, busy 0, synchroniser and edge flops 0.
REQ-028 Reset SHALL NOT alter RAM contents; reset mid-BIST leaves partial data; no test resumption.
REQ-029 After reset release, led[12:15] = 0 and led[WIDTH-1:0] reflects mem at address 0 until switches change.

Verification
REQ-030 Default params, no fault: pulse sw[14] -> busy for 384 cycles, then done=1, pass=1, fail=0; every word reads 2'b10.
REQ-031 FAULT_ADDR=5: run BIST -> done=1, fail=1, pass=0, busy still exactly 384 cycles.
REQ-032 Manual: sw address 3, data 2'b11, sw[15] one cycle -> after sync, led[1:0]=2'b11 at address 3, address 4 unchanged.
REQ-033 Assert rst_n low at cycle 100 of BIST -> busy/done/pass/fail 0 immediately; new start runs full 384 cycles with pass=1.
REQ-034 sw[14] held high across completion -> no restart; sw[15]=1 during BIST -> no RAM change and pass=1.
REQ-035 ADDR_W=4, WIDTH=4: BIST takes 48 cycles, pass=1, words read 4'b1010; tx follows rx throughout.
